tank_plant_model: RTL and testbench

- Sequential model of the irrigation water tank: the plant on the other end of the irrigation controller.
- Consumes the controller's actuator outputs: inlet valve Ve, sprinkler pump Bs, drip valve Vs, alarm Al.
- Integrates the water volume over time and produces the level-sensor inputs H, M, L that the controller reads.
- Closes the loop in simulation and on the FPGA demo board. Also flags overflow and dry-run faults.

---
 rtl/irrigation_pkg.sv | 39 +++
 rtl/tick_prescaler.sv | 32 +++
 rtl/tank_plant_model.sv | 114 +++++++++++
 tb/tb_tank_plant_model.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared constants and bundles for the irrigation controller and its tank plant.
package irrigation_pkg;

    localparam int DEF_LEVEL_W    = 8;
    localparam int DEF_CAPACITY   = 200;
    localparam int DEF_INIT_LEVEL = 50;
    localparam int DEF_L_THRESH   = 20;
    localparam int DEF_M_THRESH   = 100;
    localparam int DEF_H_THRESH   = 180;
    localparam int DEF_FILL_RATE  = 4;
    localparam int DEF_SPRAY_RATE = 3;
    localparam int DEF_DRIP_RATE  = 1;
    localparam int DEF_TICK_DIV   = 1000;

    // Level-sensor bundle read by the controller.
    typedef struct packed {
        logic h;
        logic m;
        logic l;
    } sensor_t;

    // Actuator bundle driven by the controller.
    typedef struct packed {
        logic ve;
        logic bs;
        logic vs;
        logic al;
    } actuator_t;

    // Threshold the level into the sensor bundle; monotone because L < M < H.
    function automatic sensor_t sense(input int lvl, input int lt, input int mt, input int ht);
        sensor_t s;
        s.h = (lvl >= ht);
        s.m = (lvl >= mt);
        s.l = (lvl >= lt);
        return s;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into simulation ticks: update marks the last count, tick follows it.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic update,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign update = en && (count == LAST);

    // Count while enabled, hold otherwise; register the tick pulse one cycle after update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= update;
            if (en) begin
                count <= update ? '0 : count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tank_plant_model.sv
// Water tank plant: integrates fill/drain per tick, saturates, drives H/M/L and fault flags.
module tank_plant_model
    import irrigation_pkg::*;
#(
    parameter int LEVEL_W    = DEF_LEVEL_W,
    parameter int CAPACITY   = DEF_CAPACITY,
    parameter int INIT_LEVEL = DEF_INIT_LEVEL,
    parameter int L_THRESH   = DEF_L_THRESH,
    parameter int M_THRESH   = DEF_M_THRESH,
    parameter int H_THRESH   = DEF_H_THRESH,
    parameter int FILL_RATE  = DEF_FILL_RATE,
    parameter int SPRAY_RATE = DEF_SPRAY_RATE,
    parameter int DRIP_RATE  = DEF_DRIP_RATE,
    parameter int TICK_DIV   = DEF_TICK_DIV
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               Ve,
    input  logic               Bs,
    input  logic               Vs,
    input  logic               Al,
    input  logic               clr,
    output logic               H,
    output logic               M,
    output logic               L,
    output logic [LEVEL_W-1:0] level,
    output logic               tick,
    output logic               overflow,
    output logic               dry_run
);

    localparam int RW = LEVEL_W + 2;
    typedef logic signed [RW-1:0] raw_t;

    localparam raw_t    CAP_RAW   = raw_t'(CAPACITY);
    localparam sensor_t SENS_INIT = sense(INIT_LEVEL, L_THRESH, M_THRESH, H_THRESH);

    actuator_t          act;
    logic               update;
    raw_t               fill_amt;
    raw_t               spray_amt;
    raw_t               drip_amt;
    raw_t               raw;
    logic [LEVEL_W-1:0] level_nxt;
    logic               ovf_set;
    logic               dry_set;
    sensor_t            sens;
    sensor_t            sens_nxt;

    assign act = {Ve, Bs, Vs, Al};

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .update (update),
        .tick   (tick)
    );

    // Net volume change for this tick; the alarm disables both drains but not the inlet.
    always_comb begin
        fill_amt  = act.ve ? raw_t'(FILL_RATE) : '0;
        spray_amt = (act.bs && !act.al) ? raw_t'(SPRAY_RATE) : '0;
        drip_amt  = (act.vs && !act.al) ? raw_t'(DRIP_RATE) : '0;
        raw       = $signed({2'b00, level}) + fill_amt - spray_amt - drip_amt;
    end

    // Saturate the candidate level to 0..CAPACITY and flag which bound was hit.
    always_comb begin
        level_nxt = raw[LEVEL_W-1:0];
        ovf_set   = 1'b0;
        dry_set   = 1'b0;
        if (raw > CAP_RAW) begin
            level_nxt = LEVEL_W'(CAPACITY);
            ovf_set   = 1'b1;
        end else if (raw < raw_t'(0)) begin
            level_nxt = '0;
            dry_set   = 1'b1;
        end
        sens_nxt = sense(int'(level_nxt), L_THRESH, M_THRESH, H_THRESH);
    end

    // Level and sensors move together on the update edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= LEVEL_W'(INIT_LEVEL);
            sens  <= SENS_INIT;
        end else if (update) begin
            level <= level_nxt;
            sens  <= sens_nxt;
        end
    end

    // Sticky fault flags; a new fault on the same edge as clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            dry_run  <= 1'b0;
        end else begin
            if (update && ovf_set) overflow <= 1'b1;
            else if (clr)          overflow <= 1'b0;
            if (update && dry_set) dry_run <= 1'b1;
            else if (clr)          dry_run <= 1'b0;
        end
    end

    assign H = sens.h;
    assign M = sens.m;
    assign L = sens.l;

endmodule

// File: tb/tb_tank_plant_model.sv
// Bench for tank_plant_model with TICK_DIV=4: directed scenarios plus random actuator traffic
// compared against an integer model of the tank.
module tb_tank_plant_model;

    localparam int TDIV  = 4;
    localparam int CAP   = 200;
    localparam int INIT  = 50;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ve;
    logic       bs;
    logic       vs;
    logic       al;
    logic       clr;
    logic       h_s;
    logic       m_s;
    logic       l_s;
    logic [7:0] level;
    logic       tick;
    logic       overflow;
    logic       dry_run;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_cnt;
    int m_lvl;
    int m_tick;
    int m_ovf;
    int m_dry;
    logic [7:0] exp_q[$];

    tank_plant_model #(
        .TICK_DIV (TDIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .Ve       (ve),
        .Bs       (bs),
        .Vs       (vs),
        .Al       (al),
        .clr      (clr),
        .H        (h_s),
        .M        (m_s),
        .L        (l_s),
        .level    (level),
        .tick     (tick),
        .overflow (overflow),
        .dry_run  (dry_run)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_lvl  = INIT;
        m_tick = 0;
        m_ovf  = 0;
        m_dry  = 0;
        exp_q.delete();
    endtask

    // One clock edge of the tank, from the inputs held across that edge.
    task automatic model_edge();
        int nxt;
        int do_upd;
        do_upd = (en && m_cnt == TDIV - 1);
        if (en) m_cnt = (m_cnt + 1) % TDIV;
        m_tick = do_upd;
        if (clr) begin
            m_ovf = 0;
            m_dry = 0;
        end
        if (do_upd) begin
            nxt = m_lvl + (ve ? 4 : 0) - ((bs && !al) ? 3 : 0) - ((vs && !al) ? 1 : 0);
            if (nxt > CAP) begin
                nxt   = CAP;
                m_ovf = 1;
            end else if (nxt < 0) begin
                nxt   = 0;
                m_dry = 1;
            end
            m_lvl = nxt;
            exp_q.push_back(8'(m_lvl));
        end
    endtask

    task automatic compare_all();
        check("tick", tick, m_tick);
        check("level", level, m_lvl);
        check("H", h_s, m_lvl >= 180);
        check("M", m_s, m_lvl >= 100);
        check("L", l_s, m_lvl >= 20);
        check("overflow", overflow, m_ovf);
        check("dry_run", dry_run, m_dry);
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) check("tick_unexpected", 1, 0);
            else check("sb_level", level, exp_q.pop_front());
        end
    endtask

    // driver: hold inputs over one edge, advance the model, sample 1 ns later
    task automatic step(input logic e, input logic i_ve, input logic i_bs,
                        input logic i_vs, input logic i_al, input logic i_clr);
        en  = e;
        ve  = i_ve;
        bs  = i_bs;
        vs  = i_vs;
        al  = i_al;
        clr = i_clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run_ticks(input int n, input logic i_ve, input logic i_bs,
                             input logic i_vs, input logic i_al);
        repeat (n * TDIV) step(1'b1, i_ve, i_bs, i_vs, i_al, 1'b0);
    endtask

    initial begin
        en = 0; ve = 0; bs = 0; vs = 0; al = 0; clr = 0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_level", level, INIT);
        check("rst_L", l_s, 1);
        check("rst_M", m_s, 0);
        check("rst_H", h_s, 0);
        check("rst_tick", tick, 0);
        check("rst_ovf", overflow, 0);
        check("rst_dry", dry_run, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // fill 13 ticks: 50 -> 102
        run_ticks(13, 1, 0, 0, 0);
        check("plan_fill_102", level, 102);
        check("plan_fill_M", m_s, 1);

        // fill into the ceiling
        run_ticks(25, 1, 0, 0, 0);
        check("plan_cap_level", level, CAP);
        check("plan_cap_ovf", overflow, 1);
        check("plan_cap_H", h_s, 1);
        step(0, 0, 0, 0, 0, 1);
        check("plan_clr_ovf", overflow, 0);

        // drain through zero
        run_ticks(51, 0, 1, 1, 0);
        check("plan_dry_level", level, 0);
        check("plan_dry_flag", dry_run, 1);
        check("plan_dry_L", l_s, 0);
        step(0, 0, 0, 0, 0, 1);

        // level 2, alarm masks drains, then drains unmasked
        run_ticks(1, 1, 0, 0, 0);
        run_ticks(2, 0, 0, 1, 0);
        check("plan_lvl2", level, 2);
        run_ticks(1, 0, 1, 1, 1);
        check("plan_alarm_level", level, 2);
        check("plan_alarm_dry", dry_run, 0);
        run_ticks(1, 0, 1, 1, 0);
        check("plan_noalarm_level", level, 0);
        check("plan_noalarm_dry", dry_run, 1);
        step(0, 0, 0, 0, 0, 1);

        // fill and drain net out at 100
        run_ticks(25, 1, 0, 0, 0);
        run_ticks(5, 1, 1, 1, 0);
        check("plan_net_level", level, 100);
        check("plan_net_ovf", overflow, 0);
        check("plan_net_dry", dry_run, 0);

        // en pause after two counts
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        repeat (10) step(0, 1, 0, 0, 0, 0);
        check("plan_pause_level", level, 100);
        step(1, 1, 0, 0, 0, 0);
        check("plan_resume_notick", tick, 0);
        step(1, 1, 0, 0, 0, 0);
        check("plan_resume_tick", tick, 1);
        check("plan_resume_level", level, 104);

        // random traffic
        repeat (600) begin
            step(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 15) == 0));
        end

        // reach overflow, then settle near 150 for the async reset check
        for (int i = 0; i < 100 && m_ovf == 0; i++) run_ticks(1, 1, 0, 0, 0);
        for (int i = 0; i < 100 && m_lvl > 150; i++) run_ticks(1, 0, 0, 1, 0);
        check("pre_rst_level", level, 150);
        check("pre_rst_ovf", overflow, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_level", level, INIT);
        check("async_ovf", overflow, 0);
        check("async_tick", tick, 0);
        check("async_L", l_s, 1);
        check("async_M", m_s, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_ticks(3, 1, 0, 0, 0);
        check("post_rst_level", level, 62);
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
